dled_pattern_gen: RTL and testbench

DLED_PATTERN_GEN -- requirements
Module: dled_pattern_gen

---
 rtl/dled_pkg.sv | 41 ++++
 rtl/dled_channel.sv | 133 +++++++++++++
 rtl/dled_pattern_gen.sv | 77 +++++++
 tb/tb_dled_pattern_gen.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/dled_pkg.sv
// dled_pkg: shared types and helpers for the LED pattern generator.
//   mode_e  - per-channel drive mode (OFF / ON / BLINK / BURST)
//   state_e - per-channel FSM state (STEADY / ON_PH / OFF_PH / PAUSE)
//   clamp_hp / clamp_len - map a zero half-period / burst length to 1
//   pause_term - last phase-counter value of a PAUSE phase
package dled_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_BURST = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_STEADY = 2'b00,
        ST_ON_PH  = 2'b01,
        ST_OFF_PH = 2'b10,
        ST_PAUSE  = 2'b11
    } state_e;

    localparam int HP_W    = 8;   // half-period width (ticks)
    localparam int LEN_W   = 4;   // burst length / pulse counter width
    // The phase counter has to reach PAUSE_HP*H-1 (up to 255*255-1),
    // so it is kept at 16 bits rather than the half-period width.
    localparam int PHASE_W = 16;

    function automatic logic [HP_W-1:0] clamp_hp(input logic [HP_W-1:0] v);
        return (v == '0) ? HP_W'(1) : v;
    endfunction

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] v);
        return (v == '0) ? LEN_W'(1) : v;
    endfunction

    function automatic logic [PHASE_W-1:0] pause_term(input logic [HP_W-1:0] h,
                                                      input int unsigned   php);
        return PHASE_W'(php * 32'(h)) - PHASE_W'(1);
    endfunction

endpackage

// File: rtl/dled_channel.sv
// dled_channel: one LED channel (mode register, phase/pulse counters, FSM).
// Ports:
//   clk_i          - clock
//   rst_ni         - asynchronous active-low reset (already synchronised)
//   tick_i         - shared prescaler strobe; phase counters advance only on it
//   mode_i[1:0]    - requested mode; any difference from the registered copy
//                    restarts the channel and overrides a same-cycle tick
//   half_period_i  - half-period in ticks (0 treated as 1)
//   burst_len_i    - pulses per burst (0 treated as 1)
//   dled_o         - registered LED drive, updated on the same edge as the FSM
//   state_o        - current FSM state, for debug/observation
module dled_channel
    import dled_pkg::*;
#(
    parameter int PAUSE_HP = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             tick_i,
    input  logic [1:0]       mode_i,
    input  logic [HP_W-1:0]  half_period_i,
    input  logic [LEN_W-1:0] burst_len_i,
    output logic             dled_o,
    output logic [1:0]       state_o
);

    state_e               state_q;
    logic [1:0]           mode_q;
    logic [PHASE_W-1:0]   phase_q;
    logic [PHASE_W-1:0]   phase_d;
    logic [LEN_W-1:0]     pulse_q;
    logic [HP_W-1:0]      h_q;
    logic [LEN_W-1:0]     n_q;
    logic                 dled_q;

    logic [HP_W-1:0]      h_in;
    logic [LEN_W-1:0]     n_in;
    logic [PHASE_W-1:0]   hp_term;
    logic [PHASE_W-1:0]   ps_term;
    logic                 mode_chg;

    assign h_in     = clamp_hp(half_period_i);
    assign n_in     = clamp_len(burst_len_i);
    assign mode_chg = (mode_i != mode_q);
    assign phase_d  = phase_q + PHASE_W'(1);
    // Terminal values use the sampled half-period, so a new half_period_i
    // only matters from the next phase boundary onwards.
    assign hp_term  = PHASE_W'(h_q) - PHASE_W'(1);
    assign ps_term  = pause_term(h_q, PAUSE_HP);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_STEADY;
            mode_q  <= 2'b00;
            phase_q <= '0;
            pulse_q <= '0;
            h_q     <= '0;
            n_q     <= '0;
            dled_q  <= 1'b0;
        end else if (mode_chg) begin
            mode_q  <= mode_i;
            phase_q <= '0;
            pulse_q <= '0;
            h_q     <= h_in;
            n_q     <= n_in;
            case (mode_i)
                MODE_OFF: begin
                    state_q <= ST_STEADY;
                    dled_q  <= 1'b0;
                end
                MODE_ON: begin
                    state_q <= ST_STEADY;
                    dled_q  <= 1'b1;
                end
                default: begin
                    state_q <= ST_ON_PH;
                    dled_q  <= 1'b1;
                end
            endcase
        end else if (tick_i) begin
            case (state_q)
                ST_ON_PH: begin
                    if (phase_q == hp_term) begin
                        state_q <= ST_OFF_PH;
                        dled_q  <= 1'b0;
                        phase_q <= '0;
                        h_q     <= h_in;
                        n_q     <= n_in;
                        // pulse_q counts completed ON phases of the burst
                        if (mode_q == MODE_BURST) pulse_q <= pulse_q + LEN_W'(1);
                    end else begin
                        phase_q <= phase_d;
                    end
                end
                ST_OFF_PH: begin
                    if (phase_q == hp_term) begin
                        phase_q <= '0;
                        h_q     <= h_in;
                        n_q     <= n_in;
                        if (mode_q == MODE_BURST && pulse_q >= n_q) begin
                            state_q <= ST_PAUSE;
                            dled_q  <= 1'b0;
                            pulse_q <= '0;
                        end else begin
                            state_q <= ST_ON_PH;
                            dled_q  <= 1'b1;
                        end
                    end else begin
                        phase_q <= phase_d;
                    end
                end
                ST_PAUSE: begin
                    if (phase_q == ps_term) begin
                        state_q <= ST_ON_PH;
                        dled_q  <= 1'b1;
                        phase_q <= '0;
                        h_q     <= h_in;
                        n_q     <= n_in;
                    end else begin
                        phase_q <= phase_d;
                    end
                end
                default: begin
                    // ST_STEADY: output fixed by mode, nothing to count
                end
            endcase
        end
    end

    assign dled_o  = dled_q;
    assign state_o = state_q;

endmodule

// File: rtl/dled_pattern_gen.sv
// dled_pattern_gen: multi-channel LED pattern generator.
// Ports:
//   clk100m_ref           - 100 MHz reference clock
//   btn                   - asynchronous active-low reset; release is
//                           synchronised with a 2-flop deassertion synchroniser
//   mode_i[2*NCH]         - per-channel mode (00 OFF, 01 ON, 10 BLINK, 11 BURST)
//   half_period_i[8*NCH]  - per-channel half-period in ticks (0 -> 1)
//   burst_len_i[4*NCH]    - per-channel pulses per burst (0 -> 1)
//   dled[NCH]             - registered LED drive, 1 = lit
//   tick_o                - one-cycle strobe on each prescaler wrap
//   dbg_state_o[2*NCH]    - per-channel FSM state (2 bits per channel)
//
// Valid/ready: none. Inputs are level-sampled every clock; there is no
// handshake, a change on mode_i is acted on in the cycle it is seen.
module dled_pattern_gen
    import dled_pkg::*;
#(
    parameter int NCH      = 3,
    parameter int TICK_DIV = 1000000,
    parameter int PAUSE_HP = 4
) (
    input  logic                 clk100m_ref,
    input  logic                 btn,
    input  logic [2*NCH-1:0]     mode_i,
    input  logic [HP_W*NCH-1:0]  half_period_i,
    input  logic [LEN_W*NCH-1:0] burst_len_i,
    output logic [NCH-1:0]       dled,
    output logic                 tick_o,
    output logic [2*NCH-1:0]     dbg_state_o
);

    localparam int                CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [1:0]       sync_q;
    logic             rst_n;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Assertion passes straight through; release needs two clean edges.
    always_ff @(posedge clk100m_ref or negedge btn) begin
        if (!btn) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    assign rst_n = sync_q[1];

    assign tick_o = (cnt_q == CNT_LAST);
    assign cnt_d  = tick_o ? '0 : cnt_q + CNT_W'(1);

    always_ff @(posedge clk100m_ref or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        dled_channel #(
            .PAUSE_HP(PAUSE_HP)
        ) u_ch (
            .clk_i        (clk100m_ref),
            .rst_ni       (rst_n),
            .tick_i       (tick_o),
            .mode_i       (mode_i[2*i +: 2]),
            .half_period_i(half_period_i[HP_W*i +: HP_W]),
            .burst_len_i  (burst_len_i[LEN_W*i +: LEN_W]),
            .dled_o       (dled[i]),
            .state_o      (dbg_state_o[2*i +: 2])
        );
    end

endmodule

// File: tb/tb_dled_pattern_gen.sv
// tb_dled_pattern_gen: directed bench for dled_pattern_gen with
// NCH=3, TICK_DIV=4, PAUSE_HP=2. Outputs are sampled on the falling edge,
// inputs are driven right after sampling.
module tb_dled_pattern_gen;

    localparam int NCH      = 3;
    localparam int TICK_DIV = 4;
    localparam int PAUSE_HP = 2;

    logic              clk;
    logic              btn;
    logic [2*NCH-1:0]  mode;
    logic [8*NCH-1:0]  hp;
    logic [4*NCH-1:0]  bl;
    logic [NCH-1:0]    dled;
    logic              tick;
    logic [2*NCH-1:0]  dbg_state;

    int total;
    int bad;

    dled_pattern_gen #(
        .NCH     (NCH),
        .TICK_DIV(TICK_DIV),
        .PAUSE_HP(PAUSE_HP)
    ) dut (
        .clk100m_ref  (clk),
        .btn          (btn),
        .mode_i       (mode),
        .half_period_i(hp),
        .burst_len_i  (bl),
        .dled         (dled),
        .tick_o       (tick),
        .dbg_state_o  (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Wait (bounded) until dled[ch] equals val; expiry counts as a failure.
    task automatic wait_level(input int ch, input logic val, input int budget, input string tag);
        int n;
        n = 0;
        while (dled[ch] !== val && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(dled[ch]), 32'(val));
    endtask

    // Count consecutive falling-edge samples of dled[ch]==val, from the
    // current sample on; leaves the bench at the first differing sample.
    task automatic run_check(input int ch, input logic val, input int exp_len, input string tag);
        int n;
        n = 0;
        while (dled[ch] === val && n < exp_len + 50) begin
            n++;
            @(negedge clk);
        end
        check(tag, 32'(n), 32'(exp_len));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [5:0] tick_pat;
        int n;
        total = 0;
        bad   = 0;
        btn   = 1'b0;
        mode  = 6'b01_01_01;
        hp    = {8'd1, 8'd1, 8'd1};
        bl    = {4'd1, 4'd1, 4'd1};

        // Reset held: everything dark and idle.
        repeat (5) @(negedge clk);
        check("reset_dled", 32'(dled), 32'd0);
        check("reset_tick", 32'(tick), 32'd0);
        check("reset_state", 32'(dbg_state), 32'd0);

        // Release: two synchroniser edges, then modes 01 light all LEDs.
        btn = 1'b1;
        @(negedge clk);
        check("rel_sync1", 32'(dled), 32'd0);
        @(negedge clk);
        check("rel_sync2", 32'(dled), 32'd0);
        @(negedge clk);
        check("rel_on", 32'(dled), 32'b111);
        check("rel_state", 32'(dbg_state), 32'd0);
        // Prescaler started on the same edge: tick after 3 more, then every 4.
        tick_pat = 6'b100010;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("tick_k%0d", k + 4), 32'(tick), 32'(tick_pat[k]));
        end

        // BLINK ch0, H=3: 12 high / 12 low.
        mode[1:0] = 2'b10;
        hp[7:0]   = 8'd3;
        @(negedge clk);
        check("blink_start", 32'(dled[0]), 32'd1);
        check("blink_state", 32'(dbg_state[1:0]), 32'd1);
        wait_level(0, 1'b0, 40, "blink_wait_low");
        run_check(0, 1'b0, 12, "blink_low1");
        run_check(0, 1'b1, 12, "blink_high1");
        run_check(0, 1'b0, 12, "blink_low2");
        check("blink_others", 32'(dled[2:1]), 32'b11);

        // Mode change on a tick cycle while ch0 is in a BLINK low phase:
        // switch to BURST H=3 N=2, the tick is ignored and ON_PH starts fresh.
        n = 0;
        while (!(dled[0] === 1'b0 && tick === 1'b1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("coinc_found", 32'({dled[0], tick}), 32'b01);
        mode[1:0] = 2'b11;
        bl[3:0]   = 4'd2;
        @(negedge clk);
        check("coinc_dled", 32'(dled), 32'b111);
        check("coinc_tick", 32'(tick), 32'd0);
        check("coinc_state", 32'(dbg_state), 32'b00_00_01);
        run_check(0, 1'b1, 12, "burst0_high1");
        run_check(0, 1'b0, 12, "burst0_low1");
        run_check(0, 1'b1, 12, "burst0_high2");
        run_check(0, 1'b0, 36, "burst0_pause");
        run_check(0, 1'b1, 12, "burst0_high3");

        // BURST ch1, H=1, N=3.
        mode[3:2] = 2'b11;
        hp[15:8]  = 8'd1;
        bl[7:4]   = 4'd3;
        @(negedge clk);
        wait_level(1, 1'b0, 20, "burst1_wait_low");
        run_check(1, 1'b0, 4, "burst1_off1");
        run_check(1, 1'b1, 4, "burst1_p2");
        run_check(1, 1'b0, 4, "burst1_off2");
        run_check(1, 1'b1, 4, "burst1_p3");
        run_check(1, 1'b0, 12, "burst1_pause");
        run_check(1, 1'b1, 4, "burst1_p1");
        run_check(1, 1'b0, 4, "burst1_off1b");

        // half_period=0 behaves as H=1 (ch2 BLINK).
        mode[5:4]  = 2'b10;
        hp[23:16]  = 8'd0;
        @(negedge clk);
        wait_level(2, 1'b0, 20, "hp0_wait_low");
        run_check(2, 1'b0, 4, "hp0_low");
        run_check(2, 1'b1, 4, "hp0_high");
        run_check(2, 1'b0, 4, "hp0_low2");

        // burst_len=0 behaves as N=1 (ch1 via OFF, then BURST).
        mode[3:2] = 2'b00;
        @(negedge clk);
        check("ch1_off", 32'(dled[1]), 32'd0);
        check("ch1_off_state", 32'(dbg_state[3:2]), 32'd0);
        mode[3:2] = 2'b11;
        bl[7:4]   = 4'd0;
        wait_level(1, 1'b1, 5, "bl0_start");
        wait_level(1, 1'b0, 20, "bl0_wait_low");
        run_check(1, 1'b0, 12, "bl0_low");
        run_check(1, 1'b1, 4, "bl0_high");
        run_check(1, 1'b0, 12, "bl0_low2");

        // half_period=255 on a running BLINK, no mode change: the value is
        // picked up at the next boundary and then holds for 255 ticks.
        begin
            logic v;
            hp[23:16] = 8'd255;
            v = dled[2];
            wait_level(2, ~v, 20, "hp255_wait");
            run_check(2, ~v, 1020, "hp255_run1");
            run_check(2, v, 1020, "hp255_run2");
        end

        // Reset in the middle of a ch1 PAUSE.
        n = 0;
        while (dbg_state[3:2] !== 2'b11 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("pause_found", 32'(dbg_state[3:2]), 32'd3);
        btn = 1'b0;
        #1;
        check("async_dled", 32'(dled), 32'd0);
        check("async_tick", 32'(tick), 32'd0);
        check("async_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        @(negedge clk);
        btn = 1'b1;
        @(negedge clk);
        check("rel2_sync1", 32'(dled), 32'd0);
        @(negedge clk);
        check("rel2_sync2", 32'(dled), 32'd0);
        @(negedge clk);
        check("rel2_dled", 32'(dled), 32'b111);
        check("rel2_state", 32'(dbg_state), 32'b01_01_01);
        run_check(1, 1'b1, 3, "rel2_first_pulse");
        run_check(1, 1'b0, 12, "rel2_pause");
        run_check(1, 1'b1, 4, "rel2_next_pulse");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
